// File: rtl/tagged_btb_predictor_pkg.sv
// Shared definitions for the tagged BTB predictor: register width,
// default geometry and saturating-counter state helpers.
package tagged_btb_predictor_pkg;

  localparam int REG_W = 32;

  localparam int DEF_INDEX_BITS = 6;
  localparam int DEF_TAG_BITS   = 8;
  localparam int DEF_CTR_BITS   = 2;
  localparam int DEF_RAS_DEPTH  = 4;

  // Lowest counter value that still predicts taken (MSB set, rest clear).
  function automatic int unsigned ctr_weak_taken(input int bits);
    return 32'd1 << (bits - 1);
  endfunction

  // Saturated "strongly taken" counter value (all ones).
  function automatic int unsigned ctr_strong_taken(input int bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

  localparam int unsigned CTR_WEAK_TAKEN_DEF   = ctr_weak_taken(DEF_CTR_BITS);
  localparam int unsigned CTR_STRONG_TAKEN_DEF = ctr_strong_taken(DEF_CTR_BITS);
  localparam int unsigned CTR_STRONG_NT        = 0;

endpackage

// File: rtl/tagged_btb_predictor_ras.sv
// Circular return-address stack. The pointer names the next free slot, so
// the top of stack sits one below it. A full push overwrites the oldest
// entry; a pop on an empty stack is dropped; push+pop together rewrites
// the top in place.
module bp_ras
  import tagged_btb_predictor_pkg::*;
#(
  parameter int DEPTH = DEF_RAS_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [REG_W-1:0] data_i,
  output logic [REG_W-1:0] top_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [REG_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] top_ptr;
  logic             wr_en;
  logic [PTR_W-1:0] wr_addr;

  assign top_ptr = ptr_q - PTR_W'(1);
  assign top_o   = mem_q[top_ptr];
  assign empty_o = (cnt_q == '0);

  // Next pointer/count and write slot for push, pop or replace.
  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_addr = ptr_q;
    if (push_i && pop_i) begin
      wr_en = 1'b1;
      if (cnt_q == '0) begin
        ptr_d = ptr_q + PTR_W'(1);
        cnt_d = CNT_W'(1);
      end else begin
        wr_addr = top_ptr;
      end
    end else if (push_i) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + PTR_W'(1);
      if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i && (cnt_q != '0)) begin
      ptr_d = top_ptr;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Stack storage is not reset; occupancy alone decides what is live.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_en) mem_q[wr_addr] <= data_i;
  end

endmodule

// File: rtl/tagged_btb_predictor.sv
// Direct-mapped tagged branch target buffer with per-entry saturating
// counters and a return-address stack for return-flagged entries. The
// fetch port predicts combinationally; the decode update port recomputes
// the prediction for the resolved PC, flags mispredictions and trains.
module tagged_btb_predictor
  import tagged_btb_predictor_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int TAG_BITS   = DEF_TAG_BITS,
  parameter int CTR_BITS   = DEF_CTR_BITS,
  parameter int RAS_DEPTH  = DEF_RAS_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] if_predict_pc_i,
  output logic             if_predict_hit_o,
  output logic             if_predict_taken_o,
  output logic [REG_W-1:0] if_predict_targetPc_o,
  input  logic             id_update_valid_i,
  input  logic [REG_W-1:0] id_update_pc_i,
  input  logic             id_update_isJumpInst_i,
  input  logic             id_update_isCall_i,
  input  logic             id_update_isRet_i,
  input  logic             id_update_taken_i,
  input  logic [REG_W-1:0] id_update_targetPc_i,
  output logic             id_update_failed_o,
  output logic [REG_W-1:0] id_flush_pc_o
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(ctr_weak_taken(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_MAX  = CTR_BITS'(ctr_strong_taken(CTR_BITS));

  logic [ENTRIES-1:0]  valid_q;
  logic [ENTRIES-1:0]  ret_q;
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [REG_W-1:0]    target_q [ENTRIES];

  logic [INDEX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0]   lk_tag, up_tag;
  logic                  lk_hit;
  logic                  up_hit, up_pred_taken, up_jt;
  logic [REG_W-1:0]      up_pred_target, up_pc_plus4;

  logic                  ras_push, ras_pop, ras_empty;
  logic [REG_W-1:0]      ras_top;

  logic                  ent_we, ent_meta_we, ent_valid_d;
  logic [CTR_BITS-1:0]   ent_ctr_d;

  logic                  unused_lk_pc_bits;

  assign lk_idx = if_predict_pc_i[INDEX_BITS+1:2];
  assign lk_tag = if_predict_pc_i[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign up_idx = id_update_pc_i[INDEX_BITS+1:2];
  assign up_tag = id_update_pc_i[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign unused_lk_pc_bits = ^{if_predict_pc_i[REG_W-1:INDEX_BITS+TAG_BITS+2],
                               if_predict_pc_i[1:0]};

  assign up_pc_plus4 = id_update_pc_i + REG_W'(4);
  assign up_jt       = id_update_isJumpInst_i && id_update_taken_i;

  // Fetch-side lookup; a return entry is only trusted while the RAS holds data.
  always_comb begin
    lk_hit                = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    if_predict_hit_o      = lk_hit;
    if_predict_taken_o    = lk_hit && ctr_q[lk_idx][CTR_BITS-1] &&
                            !(ret_q[lk_idx] && ras_empty);
    if_predict_targetPc_o = (ret_q[lk_idx] && !ras_empty) ? ras_top : target_q[lk_idx];
  end

  // Re-derive what fetch would have predicted for the resolved PC and judge it.
  always_comb begin
    up_hit         = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_pred_taken  = up_hit && ctr_q[up_idx][CTR_BITS-1] &&
                     !(ret_q[up_idx] && ras_empty);
    up_pred_target = (ret_q[up_idx] && !ras_empty) ? ras_top : target_q[up_idx];
    id_update_failed_o = id_update_valid_i && (
        (id_update_isJumpInst_i && (up_pred_taken != id_update_taken_i)) ||
        (up_jt && up_pred_taken && (up_pred_target != id_update_targetPc_i)) ||
        (!id_update_isJumpInst_i && up_pred_taken));
    id_flush_pc_o = up_jt ? id_update_targetPc_i : up_pc_plus4;
  end

  // Training decision for the single entry addressed by the update PC.
  always_comb begin
    ent_we      = 1'b0;
    ent_meta_we = 1'b0;
    ent_valid_d = valid_q[up_idx];
    ent_ctr_d   = ctr_q[up_idx];
    if (id_update_valid_i) begin
      if (up_jt) begin
        ent_we      = 1'b1;
        ent_meta_we = 1'b1;
        ent_valid_d = 1'b1;
        if (!up_hit)                     ent_ctr_d = CTR_WEAK;
        else if (ctr_q[up_idx] != CTR_MAX) ent_ctr_d = ctr_q[up_idx] + CTR_BITS'(1);
      end else if (id_update_isJumpInst_i) begin
        if (up_hit) begin
          ent_we = 1'b1;
          if (ctr_q[up_idx] != '0) ent_ctr_d = ctr_q[up_idx] - CTR_BITS'(1);
        end
      end else if (up_hit) begin
        // A non-branch hitting the table means the entry is a stale alias.
        ent_we      = 1'b1;
        ent_valid_d = 1'b0;
      end
    end
  end

  // Valid bits and counters; reset wins over any concurrent update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= '0;
    end else if (ent_we) begin
      valid_q[up_idx] <= ent_valid_d;
      ctr_q[up_idx]   <= ent_ctr_d;
    end
  end

  // Tag, target and return flag are rewritten on every taken jump.
  always_ff @(posedge clk_i) begin
    if (!rst_i && ent_meta_we) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= id_update_targetPc_i;
      ret_q[up_idx]    <= id_update_isRet_i;
    end
  end

  assign ras_push = id_update_valid_i && up_jt && id_update_isCall_i;
  assign ras_pop  = id_update_valid_i && up_jt && id_update_isRet_i;

  bp_ras #(
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (ras_push),
    .pop_i  (ras_pop),
    .data_i (up_pc_plus4),
    .top_o  (ras_top),
    .empty_o(ras_empty)
  );

endmodule

// File: tb/tb_tagged_btb_predictor.sv
// Scoreboard bench for tagged_btb_predictor with default parameters.
module tb_tagged_btb_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] if_predict_pc_i;
  logic        if_predict_hit_o;
  logic        if_predict_taken_o;
  logic [31:0] if_predict_targetPc_o;
  logic        id_update_valid_i;
  logic [31:0] id_update_pc_i;
  logic        id_update_isJumpInst_i;
  logic        id_update_isCall_i;
  logic        id_update_isRet_i;
  logic        id_update_taken_i;
  logic [31:0] id_update_targetPc_i;
  logic        id_update_failed_o;
  logic [31:0] id_flush_pc_o;

  always #5 clk_i = ~clk_i;

  tagged_btb_predictor dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .if_predict_pc_i       (if_predict_pc_i),
    .if_predict_hit_o      (if_predict_hit_o),
    .if_predict_taken_o    (if_predict_taken_o),
    .if_predict_targetPc_o (if_predict_targetPc_o),
    .id_update_valid_i     (id_update_valid_i),
    .id_update_pc_i        (id_update_pc_i),
    .id_update_isJumpInst_i(id_update_isJumpInst_i),
    .id_update_isCall_i    (id_update_isCall_i),
    .id_update_isRet_i     (id_update_isRet_i),
    .id_update_taken_i     (id_update_taken_i),
    .id_update_targetPc_i  (id_update_targetPc_i),
    .id_update_failed_o    (id_update_failed_o),
    .id_flush_pc_o         (id_flush_pc_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int step_no  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  typedef enum int {K_HIT, K_TAKEN, K_TARGET, K_FAILED, K_FLUSH} kind_e;
  typedef struct {
    string       tag;
    kind_e       kind;
    logic [31:0] exp;
  } sb_item_t;
  sb_item_t sb[$];

  // Reference model: 64 entries, tag pc[15:8], 2-bit counters, 4-deep RAS.
  bit          m_valid [64];
  bit          m_ret   [64];
  logic [7:0]  m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];
  logic [31:0] m_ras   [4];
  int          m_ptr, m_cnt;

  function automatic logic [31:0] m_top();
    return m_ras[(m_ptr + 3) % 4];
  endfunction

  function automatic void m_predict(input logic [31:0] pc, output bit hit,
                                    output bit tk, output logic [31:0] tgt);
    int i;
    bit empty;
    i     = int'(pc[7:2]);
    empty = (m_cnt == 0);
    hit   = m_valid[i] && (m_tag[i] == pc[15:8]);
    tk    = hit && (m_ctr[i] >= 2) && !(m_ret[i] && empty);
    tgt   = (m_ret[i] && !empty) ? m_top() : m_tgt[i];
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 0;
    end
    m_ptr = 0;
    m_cnt = 0;
  endfunction

  function automatic void m_update(input logic [31:0] pc, input bit j, input bit c,
                                   input bit r, input bit t, input logic [31:0] tgt);
    int i;
    bit hit, ptk;
    logic [31:0] ptgt;
    i = int'(pc[7:2]);
    m_predict(pc, hit, ptk, ptgt);
    if (j && t) begin
      m_ctr[i]   = hit ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : 2;
      m_valid[i] = 1;
      m_tag[i]   = pc[15:8];
      m_tgt[i]   = tgt;
      m_ret[i]   = r;
      if (c && r) begin
        if (m_cnt == 0) begin
          m_ras[m_ptr] = pc + 32'd4;
          m_ptr = (m_ptr + 1) % 4;
          m_cnt = 1;
        end else begin
          m_ras[(m_ptr + 3) % 4] = pc + 32'd4;
        end
      end else if (c) begin
        m_ras[m_ptr] = pc + 32'd4;
        m_ptr = (m_ptr + 1) % 4;
        if (m_cnt < 4) m_cnt++;
      end else if (r && m_cnt > 0) begin
        m_ptr = (m_ptr + 3) % 4;
        m_cnt--;
      end
    end else if (j) begin
      if (hit && m_ctr[i] > 0) m_ctr[i]--;
    end else if (hit) begin
      m_valid[i] = 0;
    end
  endfunction

  function automatic void sb_push(input string nm, input kind_e k, input logic [31:0] v);
    sb_item_t it;
    it.tag  = $sformatf("s%0d_%s", step_no, nm);
    it.kind = k;
    it.exp  = v;
    sb.push_back(it);
  endfunction

  // One cycle: drive, queue expectations, compare at negedge, advance model at posedge.
  task automatic step(input bit r, input logic [31:0] lpc, input bit v, input logic [31:0] upc,
                      input bit j, input bit c, input bit rt, input bit t, input logic [31:0] utgt);
    bit lh, lt, uh, ut, exp_fail;
    logic [31:0] ltg, utg, obs;
    sb_item_t it;
    step_no++;
    rst_i = r;
    if_predict_pc_i        = lpc;
    id_update_valid_i      = v;
    id_update_pc_i         = upc;
    id_update_isJumpInst_i = j;
    id_update_isCall_i     = c;
    id_update_isRet_i      = rt;
    id_update_taken_i      = t;
    id_update_targetPc_i   = utgt;

    m_predict(lpc, lh, lt, ltg);
    m_predict(upc, uh, ut, utg);
    exp_fail = v && ((j && (ut != t)) || (j && t && ut && (utg != utgt)) || (!j && ut));
    sb_push("hit", K_HIT, {31'd0, lh});
    sb_push("taken", K_TAKEN, {31'd0, lt});
    if (lh) sb_push("target", K_TARGET, ltg);
    sb_push("failed", K_FAILED, {31'd0, exp_fail});
    sb_push("flush", K_FLUSH, (j && t) ? utgt : upc + 32'd4);

    @(negedge clk_i);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      case (it.kind)
        K_HIT:    obs = {31'd0, if_predict_hit_o};
        K_TAKEN:  obs = {31'd0, if_predict_taken_o};
        K_TARGET: obs = if_predict_targetPc_o;
        K_FAILED: obs = {31'd0, id_update_failed_o};
        default:  obs = id_flush_pc_o;
      endcase
      check_val(it.tag, obs, it.exp);
    end

    @(posedge clk_i);
    if (r) m_reset();
    else if (v) m_update(upc, j, c, rt, t, utgt);
    #1;
  endtask

  localparam logic [31:0] A  = 32'h8000_0010;
  localparam logic [31:0] AL = 32'h8000_0410;
  localparam logic [31:0] TA = 32'h8000_0100;
  localparam logic [31:0] B  = 32'h8000_0020;
  localparam logic [31:0] TB = 32'h8000_0200;
  localparam logic [31:0] R  = 32'h8000_0080;
  localparam logic [31:0] CB = 32'h8000_0000;

  logic [31:0] ret_exp [4];
  logic [31:0] pcs [8];

  initial begin
    ret_exp[0] = 32'h8000_0044; ret_exp[1] = 32'h8000_0034;
    ret_exp[2] = 32'h8000_0024; ret_exp[3] = 32'h8000_0014;
    pcs[0] = 32'h8000_0010; pcs[1] = 32'h8000_0410; pcs[2] = 32'h8000_0020;
    pcs[3] = 32'h8000_0820; pcs[4] = 32'h8000_0030; pcs[5] = 32'h8000_0080;
    pcs[6] = 32'h8000_0110; pcs[7] = 32'h8000_0044;

    rst_i = 1'b1;
    if_predict_pc_i = A;
    id_update_valid_i = 0; id_update_pc_i = A; id_update_isJumpInst_i = 0;
    id_update_isCall_i = 0; id_update_isRet_i = 0; id_update_taken_i = 0;
    id_update_targetPc_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    m_reset();

    // Reset state and first allocation, including same-cycle lookup of old state.
    step(0, A, 0, A, 0, 0, 0, 0, 0);
    step(0, A, 1, A, 1, 0, 0, 1, TA);
    step(0, A, 1, A, 1, 0, 0, 1, TA);
    // Alias handling.
    step(0, AL, 1, AL, 0, 0, 0, 0, 0);
    step(0, A, 1, A, 0, 0, 0, 0, 0);
    step(0, A, 0, A, 0, 0, 0, 0, 0);

    // Counter saturation and decay.
    for (int k = 0; k < 4; k++) step(0, B, 1, B, 1, 0, 0, 1, TB);
    for (int k = 0; k < 3; k++) step(0, B, 1, B, 1, 0, 0, 0, TB);
    step(0, B, 0, B, 0, 0, 0, 0, 0);

    // Return prediction through the RAS.
    step(0, R, 1, R, 1, 0, 1, 1, 32'h1234_5678);
    step(0, R, 0, R, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, R, 1, CB + 32'(k * 16), 1, 1, 0, 1, 32'h8000_1000);
    for (int k = 0; k < 4; k++) step(0, R, 1, R, 1, 0, 1, 1, ret_exp[k]);
    step(0, R, 0, R, 0, 0, 0, 0, 0);
    // Call and return together: empty stack pushes, then replaces top.
    step(0, R, 1, 32'h8000_0300, 1, 1, 1, 1, 32'h8000_2000);
    step(0, R, 1, 32'h8000_0500, 1, 1, 1, 1, 32'h8000_2000);
    step(0, R, 0, R, 0, 0, 0, 0, 0);

    // Randomised traffic over aliasing PCs.
    for (int k = 0; k < 60; k++) begin
      logic [31:0] up, lp;
      bit jj;
      up = pcs[$urandom_range(0, 7)];
      lp = pcs[$urandom_range(0, 7)];
      jj = ($urandom_range(0, 3) != 0);
      step(0, lp, ($urandom_range(0, 4) != 0), up, jj,
           jj && ($urandom_range(0, 3) == 0), jj && ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) != 0), 32'h8000_0000 | ($urandom_range(0, 3) << 4));
    end

    // Reset in the middle of traffic beats a simultaneous taken update.
    step(0, B, 1, B, 1, 0, 0, 1, TB);
    step(1, B, 1, A, 1, 0, 0, 1, TA);
    step(0, A, 0, B, 0, 0, 0, 0, 0);
    step(0, B, 0, R, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
